uart_tx_responder: RTL



---
 rtl/uart_tx_responder.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_responder.sv
// uart_tx_responder: memory-mapped 8N1 UART transmitter with a byte FIFO.
// Optional idle interrupt and IER register are built when UART_TX_IRQ_EN is defined.
//
// Ports:
//   clk, rst        - system clock, asynchronous active-high reset
//   bus_req/bus_we  - request strobe (already window-decoded), 1 = write
//   bus_addr        - byte address, only [11:0] decoded
//   bus_wdata       - write data, THR takes [7:0]
//   bus_rdata       - registered read data, valid while bus_ready
//   bus_ready       - registered one-cycle acknowledge per sampled request
//   tx              - registered serial output, idle high
//   irq             - registered transmit-idle level interrupt
//
// Register map: 0x000 THR (wo), 0x004 STATUS (ro), 0x008 IER (rw).
// STATUS: bit0 full, bit1 empty, bit2 busy, bit3 overflow (sticky, read-clear).
module uart_tx_responder #(
    parameter int XLEN       = 32,
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            bus_req,
    input  logic            bus_we,
    input  logic [XLEN-1:0] bus_addr,
    input  logic [XLEN-1:0] bus_wdata,
    output logic [XLEN-1:0] bus_rdata,
    output logic            bus_ready,
    output logic            tx,
    output logic            irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] BAUD_LOAD = CW'(CLK_DIV - 1);
    localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] baud, baud_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shreg, shreg_n;
    logic          tx_n;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    logic          ovf;
    logic          ier_rd;
    logic [XLEN-1:0] rdata_d;

    logic [11:0] off;
    logic sel_thr, sel_status, sel_ier;
    logic wr, rd;
    logic full, empty, busy;
    logic pop, push, ovf_set;

    logic unused_bits;
    assign unused_bits = ^{bus_addr[XLEN-1:12], bus_wdata[XLEN-1:8]};

    assign off        = bus_addr[11:0];
    assign sel_thr    = (off == 12'h000);
    assign sel_status = (off == 12'h004);
    assign sel_ier    = (off == 12'h008);
    assign wr         = bus_req & bus_we;
    assign rd         = bus_req & ~bus_we;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign busy  = (state != S_IDLE);

    // A full FIFO still accepts a push when the serializer pops the same edge.
    assign pop     = (state == S_IDLE) & ~empty;
    assign push    = wr & sel_thr & (~full | pop);
    assign ovf_set = wr & sel_thr & full & ~pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus_wdata[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (ovf_set) begin
            ovf <= 1'b1;
        end else if (rd & sel_status) begin
            ovf <= 1'b0;
        end
    end

`ifdef UART_TX_IRQ_EN
    logic ier;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ier <= 1'b0;
            irq <= 1'b0;
        end else begin
            if (wr & sel_ier) ier <= bus_wdata[0];
            irq <= ier & empty & ~busy;
        end
    end

    assign ier_rd = ier;
`else
    assign ier_rd = 1'b0;
    assign irq    = 1'b0;
`endif

    always_comb begin
        rdata_d = '0;
        unique case (1'b1)
            sel_status: rdata_d = {{(XLEN-4){1'b0}}, ovf, busy, empty, full};
            sel_ier:    rdata_d = {{(XLEN-1){1'b0}}, ier_rd};
            default:    rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_ready <= 1'b0;
            bus_rdata <= '0;
        end else begin
            bus_ready <= bus_req;
            bus_rdata <= rd ? rdata_d : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_n;
            shreg   <= shreg_n;
            tx      <= tx_n;
        end
    end

    always_comb begin
        state_n = state;
        baud_n  = baud;
        bit_n   = bit_idx;
        shreg_n = shreg;
        tx_n    = 1'b1;
        unique case (state)
            S_IDLE: begin
                if (!empty) begin
                    shreg_n = mem[rd_ptr];
                    baud_n  = BAUD_LOAD;
                    state_n = S_START;
                end
            end
            S_START: begin
                tx_n = 1'b0;
                if (baud == '0) begin
                    baud_n  = BAUD_LOAD;
                    bit_n   = 3'd0;
                    state_n = S_DATA;
                end else begin
                    baud_n = baud - 1'b1;
                end
            end
            S_DATA: begin
                tx_n = shreg[bit_idx];
                if (baud == '0) begin
                    baud_n = BAUD_LOAD;
                    if (bit_idx == 3'd7) begin
                        state_n = S_STOP;
                    end else begin
                        bit_n = bit_idx + 3'd1;
                    end
                end else begin
                    baud_n = baud - 1'b1;
                end
            end
            S_STOP: begin
                if (baud == '0) begin
                    state_n = S_IDLE;
                end else begin
                    baud_n = baud - 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule
